// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared constants for the multiply/divide unit: the default word width and
//   the MDOp operation codes driven by the execute stage, plus small decode
//   helpers used by the unit itself.
package muldiv_unit_pkg;

   localparam int MD_WORD_WIDTH = 32;

   // MDOp codes, shared with the execute-stage decoder.
   localparam logic [2:0] MD_NOP   = 3'b000;
   localparam logic [2:0] MD_MULT  = 3'b001;
   localparam logic [2:0] MD_MULTU = 3'b010;
   localparam logic [2:0] MD_DIV   = 3'b011;
   localparam logic [2:0] MD_DIVU  = 3'b100;
   localparam logic [2:0] MD_MTHI  = 3'b101;
   localparam logic [2:0] MD_MTLO  = 3'b110;

   // True for the four multi-cycle operations.
   function automatic logic md_is_muldiv(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the divide operations (signed or unsigned).
   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the operations that work on two's-complement operands.
   function automatic logic md_is_signed(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_unit_step
//   One radix-2 iteration of the multiply/divide datapath, purely combinational.
//   The 2*WORD_WIDTH accumulator is shared by both operations:
//     multiply: acc = {partial product high, multiplier (shifting out LSB-first)}
//     divide:   acc = {partial remainder, dividend/quotient (shifting MSB-first)}
// Ports:
//   is_div_i  select restoring-divide step (1) or shift-add multiply step (0)
//   acc_i     current accumulator
//   opnd_i    multiplicand (multiply) or divisor (divide)
//   acc_o     accumulator after this step
module muldiv_unit_step
   import muldiv_unit_pkg::*;
#(
   parameter int WORD_WIDTH = MD_WORD_WIDTH
) (
   input  logic                    is_div_i,
   input  logic [2*WORD_WIDTH-1:0] acc_i,
   input  logic [WORD_WIDTH-1:0]   opnd_i,
   output logic [2*WORD_WIDTH-1:0] acc_o
);

   logic [WORD_WIDTH-1:0] addend;
   logic [WORD_WIDTH:0]   sum;
   logic [WORD_WIDTH:0]   shifted;
   logic                  fits;
   logic [WORD_WIDTH-1:0] rem_sub;

   always_comb begin
      // Multiply: add the multiplicand into the high half when the current
      // multiplier bit is set; the carry becomes the new top bit after the shift.
      addend = acc_i[0] ? opnd_i : '0;
      sum    = {1'b0, acc_i[2*WORD_WIDTH-1:WORD_WIDTH]} + {1'b0, addend};

      // Divide: bring the next dividend bit into the remainder, then subtract
      // if the divisor fits. The difference is always < divisor, so it fits
      // back into WORD_WIDTH bits.
      shifted = {acc_i[2*WORD_WIDTH-1:WORD_WIDTH], acc_i[WORD_WIDTH-1]};
      fits    = (shifted >= {1'b0, opnd_i});
      rem_sub = shifted[WORD_WIDTH-1:0] - opnd_i;

      if (is_div_i) begin
         if (fits) begin
            acc_o = {rem_sub, acc_i[WORD_WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {shifted[WORD_WIDTH-1:0], acc_i[WORD_WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = {sum, acc_i[WORD_WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU/DIV/DIVU run as sign-magnitude radix-2 iterations (one per
//   cycle, WORD_WIDTH cycles) followed by a sign-fix cycle; MTHI/MTLO write
//   HI/LO in a single cycle without going busy.
//
//   Issue handshake: the requester presents start with MDOp/inA/inB; a request
//   is taken on a rising edge only if busy=0 and cancel=0 in that cycle. While
//   busy=1 the requester must hold off; start is ignored. Completion is a
//   one-cycle done pulse in the same cycle hi/lo show the new result and busy
//   has already dropped, so the next request may be issued in that cycle.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        issue request (sampled only when busy=0)
//   MDOp         operation code (see muldiv_unit_pkg)
//   inA, inB     rs / rt operands
//   cancel       flush: aborts an in-flight op, blocks an issue in IDLE
//   busy         operation in progress
//   done         one-cycle pulse when hi/lo take a mult/div result
//   hi, lo       HI / LO registers
//   dbg_state_o  FSM state (0=IDLE, 1=CALC, 2=FIX)
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WORD_WIDTH = MD_WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            MDOp,
   input  logic [WORD_WIDTH-1:0] inA,
   input  logic [WORD_WIDTH-1:0] inB,
   input  logic                  cancel,
   output logic                  busy,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] hi,
   output logic [WORD_WIDTH-1:0] lo,
   output logic [1:0]            dbg_state_o
);

   localparam int            CW        = $clog2(WORD_WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WORD_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [2*WORD_WIDTH-1:0] acc_q, acc_d;
   logic [WORD_WIDTH-1:0]   opnd_q, opnd_d;
   logic [WORD_WIDTH-1:0]   hi_q, hi_d;
   logic [WORD_WIDTH-1:0]   lo_q, lo_d;
   logic                    is_div_q, is_div_d;
   logic                    neg_q, neg_d;          // product / quotient sign
   logic                    neg_rem_q, neg_rem_d;  // remainder sign = sign(inA)
   logic                    div0_q, div0_d;
   logic                    done_q, done_d;

   logic                    op_signed, op_div, a_neg, b_neg;
   logic [WORD_WIDTH-1:0]   abs_a, abs_b;
   logic [WORD_WIDTH-1:0]   quo, rem;
   logic [2*WORD_WIDTH-1:0] prod_fix;
   logic [2*WORD_WIDTH-1:0] acc_step;

   muldiv_unit_step #(.WORD_WIDTH(WORD_WIDTH)) u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_step)
   );

   assign op_signed = md_is_signed(MDOp);
   assign op_div    = md_is_div(MDOp);
   assign a_neg     = op_signed & inA[WORD_WIDTH-1];
   assign b_neg     = op_signed & inB[WORD_WIDTH-1];
   // The most negative value negates to itself, which read as unsigned is
   // exactly its magnitude.
   assign abs_a     = a_neg ? -inA : inA;
   assign abs_b     = b_neg ? -inB : inB;

   assign quo       = acc_q[WORD_WIDTH-1:0];
   assign rem       = acc_q[2*WORD_WIDTH-1:WORD_WIDTH];
   assign prod_fix  = neg_q ? -acc_q : acc_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               if (md_is_muldiv(MDOp)) begin
                  state_d   = S_CALC;
                  cnt_d     = '0;
                  is_div_d  = op_div;
                  neg_d     = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  div0_d    = op_div & (inB == '0);
                  opnd_d    = op_div ? abs_b : abs_a;
                  acc_d     = {{WORD_WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
               end else if (MDOp == MD_MTHI) begin
                  hi_d = inA;
               end else if (MDOp == MD_MTLO) begin
                  lo_d = inA;
               end
            end
         end

         S_CALC: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               acc_d = acc_step;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            state_d = S_IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  // Divide by zero leaves quotient all-ones and remainder equal
                  // to |inA|; restoring the dividend's sign on the remainder
                  // returns the original inA, and the quotient is not fixed.
                  lo_d = div0_q ? '1 : (neg_q ? -quo : quo);
                  hi_d = neg_rem_q ? -rem : rem;
               end else begin
                  hi_d = prod_fix[2*WORD_WIDTH-1:WORD_WIDTH];
                  lo_d = prod_fix[WORD_WIDTH-1:0];
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         done_q    <= done_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed bench for muldiv_unit. A reference model computes results with
//   plain 64-bit arithmetic and tracks busy/done/hi/lo per cycle; a compare
//   process checks the DUT against it every falling edge. Directed scenarios
//   add hand-computed expectations for results, latency and flush/reset cases.
module tb_muldiv_unit;

   localparam int W = 32;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   // ---------------- clock / reset / DUT ----------------
   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         start  = 1'b0;
   logic         cancel = 1'b0;
   logic [2:0]   MDOp   = OP_NOP;
   logic [W-1:0] inA    = '0;
   logic [W-1:0] inB    = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;
   logic [1:0]   dbg_state;

   int   n_vec  = 0;
   int   n_miss = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .MDOp        (MDOp),
      .inA         (inA),
      .inB         (inB),
      .cancel      (cancel),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .dbg_state_o (dbg_state)
   );

   // ---------------- reference model ----------------
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_hi   = '0;
   logic [W-1:0] m_lo   = '0;
   logic [W-1:0] p_hi   = '0;
   logic [W-1:0] p_lo   = '0;
   int           m_left = 0;

   function automatic void model_calc(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] rh, output logic [W-1:0] rl);
      longint      sa, sb, sq, sr;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      rh = '0;
      rl = '0;
      case (op)
         OP_MULT: begin
            sq = sa * sb;
            rh = sq[63:32];
            rl = sq[31:0];
         end
         OP_MULTU: begin
            up = {32'h0, a} * {32'h0, b};
            rh = up[63:32];
            rl = up[31:0];
         end
         OP_DIV: begin
            if (b == '0) begin
               rh = a;
               rl = '1;
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               rh = sr[31:0];
               rl = sq[31:0];
            end
         end
         OP_DIVU: begin
            if (b == '0) begin
               rh = a;
               rl = '1;
            end else begin
               rh = a % b;
               rl = a / b;
            end
         end
         default: ;
      endcase
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            if (cancel) begin
               m_busy = 1'b0;
            end else if (m_left == 1) begin
               m_busy = 1'b0;
               m_hi   = p_hi;
               m_lo   = p_lo;
               m_done = 1'b1;
            end else begin
               m_left = m_left - 1;
            end
         end else if (start && !cancel) begin
            case (MDOp)
               OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  model_calc(MDOp, inA, inB, p_hi, p_lo);
                  m_busy = 1'b1;
                  m_left = W + 1;
               end
               OP_MTHI: m_hi = inA;
               OP_MTLO: m_lo = inA;
               default: ;
            endcase
         end
      end
   end

   // ---------------- per-cycle scoreboard ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
         n_vec++;
         if ({busy, done, hi, lo} !== {m_busy, m_done, m_hi, m_lo}) begin
            n_miss++;
            $display("FAIL cycle_check t=%0t: busy %b want %b, done %b want %b, hi %h want %h, lo %h want %h",
                     $time, busy, m_busy, done, m_done, hi, m_hi, lo, m_lo);
         end
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      MDOp  = op;
      inA   = a;
      inB   = b;
      step();
      start = 1'b0;
      MDOp  = OP_NOP;
   endtask

   // Issue a mult/div, wait (bounded) for done, check latency and result.
   task automatic run_op(input string name, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int edges;
      int bc;
      issue(op, a, b);
      edges = 0;
      bc    = busy ? 1 : 0;
      while (!done && edges < 100) begin
         step();
         edges++;
         if (busy) bc++;
      end
      check({name, "_done_edge"}, 32'(edges), 32'd33);
      check({name, "_busy_cycles"}, 32'(bc), 32'd33);
      check({name, "_hi"}, hi, exp_hi);
      check({name, "_lo"}, lo, exp_lo);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int done_seen;

      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      chk_en = 1'b1;
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);

      // 1. unsigned multiply, largest operands
      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

      // 2. signed multiply, second issued in the done cycle
      run_op("mult_neg3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("mult_minsq", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

      // 3. divides
      run_op("div_neg7by2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_7by2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
      run_op("div_minbym1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_op("div_100bym7", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);

      // 4. divide by zero
      run_op("divu_by0", OP_DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
      run_op("div_neg_by0", OP_DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);

      // 5. ignored start while busy, cancel, then MTHI/MTLO
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (4) step();
      start = 1'b1; MDOp = OP_MTLO; inA = 32'hDEADBEEF;
      step();
      start = 1'b0; MDOp = OP_NOP;
      repeat (5) step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      check("cancel_busy", 32'(busy), 32'd0);
      done_seen = 0;
      repeat (40) begin
         step();
         if (done) done_seen++;
      end
      check("cancel_no_done", 32'(done_seen), 32'd0);
      check("cancel_hi_kept", hi, 32'hFFFFFFF0);
      check("cancel_lo_kept", lo, 32'hFFFFFFFF);

      issue(OP_MTHI, 32'hA5A5A5A5, 32'd0);
      check("mthi_hi", hi, 32'hA5A5A5A5);
      check("mthi_lo", lo, 32'hFFFFFFFF);
      check("mthi_busy", 32'(busy), 32'd0);
      check("mthi_done", 32'(done), 32'd0);
      issue(OP_MTLO, 32'h5A5A5A5A, 32'd0);
      check("mtlo_lo", lo, 32'h5A5A5A5A);
      check("mtlo_hi", hi, 32'hA5A5A5A5);
      check("mtlo_busy", 32'(busy), 32'd0);
      check("mtlo_done", 32'(done), 32'd0);

      // cancel together with start in IDLE: nothing issued
      cancel = 1'b1;
      issue(OP_MULTU, 32'd3, 32'd5);
      check("cancel_start_busy", 32'(busy), 32'd0);
      issue(OP_MTHI, 32'h11111111, 32'd0);
      cancel = 1'b0;
      check("cancel_mthi_hi", hi, 32'hA5A5A5A5);

      // NOP with start: ignored
      issue(OP_NOP, 32'h22222222, 32'd1);
      check("nop_busy", 32'(busy), 32'd0);
      check("nop_hi", hi, 32'hA5A5A5A5);
      check("nop_lo", lo, 32'h5A5A5A5A);
      step();

      // 6. asynchronous reset mid-operation
      issue(OP_MULTU, 32'd7, 32'd9);
      repeat (10) step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_hi", hi, 32'h0);
      check("arst_lo", lo, 32'h0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
